// File: rtl/gpio_cmd_if.sv
// GPO/GPI command interface: edge-triggered commands from a GPO word drive control outputs,
// log-memory access and BER snapshot readback. Results come back on the GPI word.
`timescale 1ns/1ps
module gpio_cmd_if #(
  parameter int NB_GPIOS        = 32,
  parameter int NB_CMD          = 8,
  parameter int N_CH            = 2,
  parameter int NB_BER_CNT      = 64,
  parameter int NB_PHASE        = 2,
  parameter int BRAM_ADDR_WIDTH = 15,
  parameter int BRAM_DATA_WIDTH = 16,
  parameter int MEM_LAT         = 2
) (
  input  logic                         clk100,
  input  logic                         i_resetn,
  input  logic [NB_GPIOS-1:0]          i_gpo,
  output logic [NB_GPIOS-1:0]          o_gpi,
  output logic                         o_rst,
  output logic                         o_enb_tx,
  output logic                         o_enb_rx,
  output logic [NB_PHASE-1:0]          o_phase_sel,
  output logic                         o_run_log,
  output logic                         o_read_log,
  output logic [BRAM_ADDR_WIDTH-1:0]   o_addr_log,
  input  logic [BRAM_DATA_WIDTH-1:0]   i_log_data,
  input  logic                         i_mem_full,
  input  logic [N_CH*NB_BER_CNT-1:0]   i_ber_samples,
  input  logic [N_CH*NB_BER_CNT-1:0]   i_ber_errors,
  output logic                         o_busy
);
  localparam int ND = NB_GPIOS - NB_CMD - 1;
  localparam int NW = (NB_BER_CNT + NB_GPIOS - 1) / NB_GPIOS;
  localparam int PW = NW * NB_GPIOS;
  localparam int CW = $clog2(MEM_LAT + 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_EXEC     = 2'd1;
  localparam logic [1:0] S_MEM_WAIT = 2'd2;

  localparam logic [NB_CMD-1:0] C_RESET    = NB_CMD'(0);
  localparam logic [NB_CMD-1:0] C_EN_TX    = NB_CMD'(1);
  localparam logic [NB_CMD-1:0] C_EN_RX    = NB_CMD'(2);
  localparam logic [NB_CMD-1:0] C_PH_SEL   = NB_CMD'(3);
  localparam logic [NB_CMD-1:0] C_RUN_MEM  = NB_CMD'(4);
  localparam logic [NB_CMD-1:0] C_READ_MEM = NB_CMD'(5);
  localparam logic [NB_CMD-1:0] C_ADDR_MEM = NB_CMD'(6);
  localparam logic [NB_CMD-1:0] C_BER_SNAP = NB_CMD'(7);
  localparam logic [NB_CMD-1:0] C_BER_RD   = NB_CMD'(8);
  localparam logic [NB_CMD-1:0] C_MEM_FULL = NB_CMD'(12);
  localparam logic [NB_CMD-1:0] C_STATUS   = NB_CMD'(13);

  logic                       en_q, en_d, en_prev_q, en_prev_d;
  logic [NB_CMD-1:0]          cmd_q, cmd_d, pend_cmd_q, pend_cmd_d;
  logic [ND-1:0]              data_q, data_d, pend_data_q, pend_data_d;
  logic                       pend_vld_q, pend_vld_d;
  logic [1:0]                 state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       mem_cmd_q, mem_cmd_d;
  logic                       rst_q, rst_d, tx_q, tx_d, rx_q, rx_d, run_q, run_d, read_q, read_d;
  logic [NB_PHASE-1:0]        phase_q, phase_d;
  logic [BRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [NB_GPIOS-1:0]        gpi_q, gpi_d;
  logic [N_CH*NB_BER_CNT-1:0] snap_smp_q, snap_smp_d, snap_err_q, snap_err_d;
  logic                       err_ovf_q, err_ovf_d, err_range_q, err_range_d, err_unk_q, err_unk_d;

  logic                acc, start, mem_last, clr_err, set_ovf, set_range, set_unk;
  logic [NB_CMD-1:0]   x_cmd;
  logic [ND-1:0]       x_data;
  logic [7:0]          ber_ch;
  logic                ber_sel;
  logic [2:0]          ber_w;
  logic                ber_ok;
  logic [PW-1:0]       ber_pad;
  logic [NB_GPIOS-1:0] ber_word;
  logic                unused_data;

  assign acc      = en_q & ~en_prev_q;
  assign start    = (state_q == S_IDLE) && (pend_vld_q || acc);
  assign mem_last = (state_q == S_MEM_WAIT) && (cnt_q == CW'(MEM_LAT - 1));
  // A pending command is always older than a fresh edge, so it executes first.
  assign x_cmd    = pend_vld_q ? pend_cmd_q : cmd_q;
  assign x_data   = pend_vld_q ? pend_data_q : data_q;
  assign ber_ch   = x_data[7:0];
  assign ber_sel  = x_data[8];
  assign ber_w    = x_data[11:9];
  assign unused_data = ^x_data;

  always_comb begin
    ber_ok   = 1'b0;
    ber_pad  = '0;
    ber_word = '0;
    for (int c = 0; c < N_CH; c++) begin
      for (int w = 0; w < NW; w++) begin
        if (32'(ber_ch) == c && 32'(ber_w) == w) begin
          ber_ok   = 1'b1;
          ber_pad  = PW'(ber_sel ? snap_err_q[c*NB_BER_CNT +: NB_BER_CNT]
                                 : snap_smp_q[c*NB_BER_CNT +: NB_BER_CNT]);
          ber_word = ber_pad[w*NB_GPIOS +: NB_GPIOS];
        end
      end
    end
  end

  always_comb begin
    en_d        = i_gpo[ND];
    en_prev_d   = en_q;
    cmd_d       = i_gpo[NB_GPIOS-1 -: NB_CMD];
    data_d      = i_gpo[ND-1:0];
    pend_vld_d  = pend_vld_q;
    pend_cmd_d  = pend_cmd_q;
    pend_data_d = pend_data_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_cmd_d   = mem_cmd_q;
    rst_d       = rst_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    run_d       = 1'b0;
    read_d      = read_q;
    phase_d     = phase_q;
    addr_d      = addr_q;
    gpi_d       = gpi_q;
    snap_smp_d  = snap_smp_q;
    snap_err_d  = snap_err_q;
    clr_err     = 1'b0;
    set_ovf     = 1'b0;
    set_range   = 1'b0;
    set_unk     = 1'b0;

    if (start && pend_vld_q) pend_vld_d = 1'b0;
    if (acc && pend_vld_q && !start) begin
      set_ovf = 1'b1;
    end else if (acc && (pend_vld_q || state_q != S_IDLE)) begin
      pend_vld_d  = 1'b1;
      pend_cmd_d  = cmd_q;
      pend_data_d = data_q;
    end

    case (state_q)
      S_IDLE: if (start) state_d = S_EXEC;
      S_EXEC: begin
        state_d = mem_cmd_q ? S_MEM_WAIT : S_IDLE;
        cnt_d   = '0;
      end
      S_MEM_WAIT: begin
        if (mem_last) state_d = S_IDLE;
        else          cnt_d   = cnt_q + CW'(1);
      end
      default: state_d = S_IDLE;
    endcase

    if (mem_last) gpi_d = NB_GPIOS'(i_log_data);

    // Command effects are registered on acceptance so they appear in the EXEC cycle.
    if (start) begin
      mem_cmd_d = (x_cmd == C_READ_MEM) || (x_cmd == C_ADDR_MEM);
      case (x_cmd)
        C_RESET:    rst_d   = x_data[0];
        C_EN_TX:    tx_d    = x_data[0];
        C_EN_RX:    rx_d    = x_data[0];
        C_PH_SEL:   phase_d = x_data[NB_PHASE-1:0];
        C_RUN_MEM:  run_d   = 1'b1;
        C_READ_MEM: begin
          read_d = 1'b1;
          addr_d = x_data[BRAM_ADDR_WIDTH-1:0];
        end
        C_ADDR_MEM: addr_d  = x_data[BRAM_ADDR_WIDTH-1:0];
        C_BER_SNAP: begin
          snap_smp_d = i_ber_samples;
          snap_err_d = i_ber_errors;
        end
        C_BER_RD: begin
          gpi_d     = ber_ok ? ber_word : '0;
          set_range = ~ber_ok;
        end
        C_MEM_FULL: gpi_d = NB_GPIOS'(i_mem_full);
        C_STATUS: begin
          gpi_d   = NB_GPIOS'({err_unk_q, err_range_q, err_ovf_q, i_mem_full,
                               read_q, rx_q, tx_q, rst_q});
          clr_err = 1'b1;
        end
        default: begin
          gpi_d   = '0;
          set_unk = 1'b1;
        end
      endcase
    end

    // Set wins over a coincident STATUS clear.
    err_ovf_d   = (err_ovf_q   & ~clr_err) | set_ovf;
    err_range_d = (err_range_q & ~clr_err) | set_range;
    err_unk_d   = (err_unk_q   & ~clr_err) | set_unk;
  end

  always_ff @(posedge clk100 or negedge i_resetn) begin
    if (!i_resetn) begin
      en_q        <= 1'b1;
      en_prev_q   <= 1'b1;
      cmd_q       <= '0;
      data_q      <= '0;
      pend_vld_q  <= 1'b0;
      pend_cmd_q  <= '0;
      pend_data_q <= '0;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mem_cmd_q   <= 1'b0;
      rst_q       <= 1'b1;
      tx_q        <= 1'b0;
      rx_q        <= 1'b0;
      run_q       <= 1'b0;
      read_q      <= 1'b0;
      phase_q     <= '0;
      addr_q      <= '0;
      gpi_q       <= '0;
      snap_smp_q  <= '0;
      snap_err_q  <= '0;
      err_ovf_q   <= 1'b0;
      err_range_q <= 1'b0;
      err_unk_q   <= 1'b0;
    end else begin
      en_q        <= en_d;
      en_prev_q   <= en_prev_d;
      cmd_q       <= cmd_d;
      data_q      <= data_d;
      pend_vld_q  <= pend_vld_d;
      pend_cmd_q  <= pend_cmd_d;
      pend_data_q <= pend_data_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_cmd_q   <= mem_cmd_d;
      rst_q       <= rst_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      run_q       <= run_d;
      read_q      <= read_d;
      phase_q     <= phase_d;
      addr_q      <= addr_d;
      gpi_q       <= gpi_d;
      snap_smp_q  <= snap_smp_d;
      snap_err_q  <= snap_err_d;
      err_ovf_q   <= err_ovf_d;
      err_range_q <= err_range_d;
      err_unk_q   <= err_unk_d;
    end
  end

  // Log data is presented during the final wait cycle and then held in gpi_q.
  assign o_gpi       = mem_last ? NB_GPIOS'(i_log_data) : gpi_q;
  assign o_rst       = rst_q;
  assign o_enb_tx    = tx_q;
  assign o_enb_rx    = rx_q;
  assign o_phase_sel = phase_q;
  assign o_run_log   = run_q;
  assign o_read_log  = read_q;
  assign o_addr_log  = addr_q;
  assign o_busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_gpio_cmd_if.sv
// Directed bench for gpio_cmd_if: each task drives one scenario and checks against hand-computed values.
`timescale 1ns/1ps
module tb_gpio_cmd_if;
  logic          clk100 = 1'b0;
  logic          i_resetn;
  logic [31:0]   i_gpo;
  logic [31:0]   o_gpi;
  logic          o_rst, o_enb_tx, o_enb_rx, o_run_log, o_read_log, o_busy;
  logic [1:0]    o_phase_sel;
  logic [14:0]   o_addr_log;
  logic [15:0]   i_log_data;
  logic          i_mem_full;
  logic [127:0]  i_ber_samples, i_ber_errors;

  int n_chk  = 0;
  int n_fail = 0;

  gpio_cmd_if dut (
    .clk100(clk100), .i_resetn(i_resetn), .i_gpo(i_gpo), .o_gpi(o_gpi),
    .o_rst(o_rst), .o_enb_tx(o_enb_tx), .o_enb_rx(o_enb_rx), .o_phase_sel(o_phase_sel),
    .o_run_log(o_run_log), .o_read_log(o_read_log), .o_addr_log(o_addr_log),
    .i_log_data(i_log_data), .i_mem_full(i_mem_full),
    .i_ber_samples(i_ber_samples), .i_ber_errors(i_ber_errors), .o_busy(o_busy)
  );

  always #5 clk100 = ~clk100;

  task automatic tick();
    @(posedge clk100); #1;
  endtask

  // Raise enable with cmd/data for one sample; returns in the acceptance cycle k.
  task automatic pulse(input logic [7:0] cmd, input logic [22:0] data);
    i_gpo = {cmd, 1'b1, data};
    tick();
    i_gpo = {cmd, 1'b0, data};
  endtask

  task automatic test_reset();
    i_resetn = 1'b0; i_gpo = '0; i_log_data = '0; i_mem_full = 1'b0;
    i_ber_samples = '0; i_ber_errors = '0;
    tick(); tick();
    n_chk++; if (o_rst !== 1'b1) begin n_fail++; $display("FAIL reset_rst: got %b expected 1", o_rst); end
    n_chk++; if ({o_enb_tx, o_enb_rx, o_run_log, o_read_log, o_busy} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 00000", {o_enb_tx, o_enb_rx, o_run_log, o_read_log, o_busy}); end
    n_chk++; if (o_gpi !== 32'h0) begin n_fail++; $display("FAIL reset_gpi: got %h expected 0", o_gpi); end
    n_chk++; if ({o_addr_log, o_phase_sel} !== 17'h0) begin
      n_fail++; $display("FAIL reset_addr_phase: got %h expected 0", {o_addr_log, o_phase_sel}); end
    i_resetn = 1'b1;
    tick(); tick();
  endtask

  task automatic test_ctrl();
    pulse(8'd0, 23'd0);
    n_chk++; if (o_rst !== 1'b1) begin n_fail++; $display("FAIL rst_early: got %b expected 1", o_rst); end
    tick();
    n_chk++; if (o_rst !== 1'b0) begin n_fail++; $display("FAIL rst_clear: got %b expected 0", o_rst); end
    tick();
    pulse(8'd1, 23'd1);
    n_chk++; if (o_enb_tx !== 1'b0) begin n_fail++; $display("FAIL tx_early: got %b expected 0", o_enb_tx); end
    tick();
    n_chk++; if (o_enb_tx !== 1'b1) begin n_fail++; $display("FAIL tx_set: got %b expected 1", o_enb_tx); end
    tick();
    pulse(8'd2, 23'd1); tick(); tick();
    n_chk++; if (o_enb_rx !== 1'b1) begin n_fail++; $display("FAIL rx_set: got %b expected 1", o_enb_rx); end
    pulse(8'd3, 23'h7FFFFE); tick(); tick();
    n_chk++; if (o_phase_sel !== 2'd2) begin n_fail++; $display("FAIL phase: got %0d expected 2", o_phase_sel); end
    i_mem_full = 1'b1;
    pulse(8'd12, 23'd0); tick();
    n_chk++; if (o_gpi !== 32'h1) begin n_fail++; $display("FAIL mem_full: got %h expected 00000001", o_gpi); end
    tick();
    i_mem_full = 1'b0;
    pulse(8'd1, 23'd0); tick(); tick();
    n_chk++; if ({o_enb_tx, o_gpi} !== {1'b0, 32'h1}) begin
      n_fail++; $display("FAIL tx_clr_gpi_hold: got %h expected %h", {o_enb_tx, o_gpi}, {1'b0, 32'h1}); end
    pulse(8'd4, 23'd0);
    n_chk++; if (o_run_log !== 1'b0) begin n_fail++; $display("FAIL run_early: got %b expected 0", o_run_log); end
    tick();
    n_chk++; if (o_run_log !== 1'b1) begin n_fail++; $display("FAIL run_pulse: got %b expected 1", o_run_log); end
    tick();
    n_chk++; if ({o_run_log, o_gpi} !== {1'b0, 32'h1}) begin
      n_fail++; $display("FAIL run_end: got %h expected %h", {o_run_log, o_gpi}, {1'b0, 32'h1}); end
  endtask

  task automatic test_ber();
    i_ber_samples = {64'h0000_0001_8000_0000, 64'h1111_2222_3333_4444};
    i_ber_errors  = {64'hDEAD_BEEF_0123_4567, 64'h0};
    pulse(8'd7, 23'd0); tick(); tick();
    i_ber_samples = {64'hFFFF_FFFF_FFFF_FFFF, 64'h5555_5555_5555_5555};
    i_ber_errors  = {64'h0, 64'h7777_7777_7777_7777};
    pulse(8'd8, 23'h201); tick();
    n_chk++; if (o_gpi !== 32'h0000_0001) begin n_fail++; $display("FAIL ber_ch1_w1: got %h expected 00000001", o_gpi); end
    tick();
    pulse(8'd8, 23'h001); tick();
    n_chk++; if (o_gpi !== 32'h8000_0000) begin n_fail++; $display("FAIL ber_ch1_w0: got %h expected 80000000", o_gpi); end
    tick();
    pulse(8'd8, 23'h301); tick();
    n_chk++; if (o_gpi !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ber_err_w1: got %h expected deadbeef", o_gpi); end
    tick();
    pulse(8'd8, 23'h000); tick();
    n_chk++; if (o_gpi !== 32'h3333_4444) begin n_fail++; $display("FAIL ber_ch0_w0: got %h expected 33334444", o_gpi); end
    tick();
    pulse(8'd8, 23'h002); tick();
    n_chk++; if (o_gpi !== 32'h0) begin n_fail++; $display("FAIL ber_bad_ch: got %h expected 0", o_gpi); end
    tick();
    pulse(8'd13, 23'd0); tick();
    n_chk++; if (o_gpi !== 32'h44) begin n_fail++; $display("FAIL status_range1: got %h expected 00000044", o_gpi); end
    tick();
    pulse(8'd8, 23'h201); tick(); tick();
    pulse(8'd8, 23'h401); tick();
    n_chk++; if (o_gpi !== 32'h0) begin n_fail++; $display("FAIL ber_bad_w: got %h expected 0", o_gpi); end
    tick();
    pulse(8'd13, 23'd0); tick();
    n_chk++; if (o_gpi !== 32'h44) begin n_fail++; $display("FAIL status_range2: got %h expected 00000044", o_gpi); end
    tick();
    pulse(8'd13, 23'd0); tick();
    n_chk++; if (o_gpi !== 32'h04) begin n_fail++; $display("FAIL status_clear: got %h expected 00000004", o_gpi); end
    tick();
  endtask

  task automatic test_read_mem();
    i_log_data = 16'hBEEF;
    pulse(8'd5, 23'h2A9C);
    n_chk++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rd_busy_k: got %b expected 0", o_busy); end
    tick();
    n_chk++; if ({o_addr_log, o_read_log, o_busy} !== {15'h2A9C, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL rd_k1: got %h expected %h", {o_addr_log, o_read_log, o_busy}, {15'h2A9C, 1'b1, 1'b1}); end
    n_chk++; if (o_gpi !== 32'h04) begin n_fail++; $display("FAIL rd_gpi_k1: got %h expected 00000004", o_gpi); end
    tick();
    n_chk++; if ({o_busy, o_gpi} !== {1'b1, 32'h04}) begin
      n_fail++; $display("FAIL rd_k2: got %h expected %h", {o_busy, o_gpi}, {1'b1, 32'h04}); end
    tick();
    n_chk++; if ({o_busy, o_gpi} !== {1'b1, 32'h0000_BEEF}) begin
      n_fail++; $display("FAIL rd_k3: got %h expected %h", {o_busy, o_gpi}, {1'b1, 32'h0000_BEEF}); end
    tick();
    n_chk++; if ({o_busy, o_gpi} !== {1'b0, 32'h0000_BEEF}) begin
      n_fail++; $display("FAIL rd_k4: got %h expected %h", {o_busy, o_gpi}, {1'b0, 32'h0000_BEEF}); end
    i_log_data = 16'h1234;
    pulse(8'd6, 23'h0123); tick();
    n_chk++; if ({o_addr_log, o_read_log} !== {15'h0123, 1'b1}) begin
      n_fail++; $display("FAIL addr_mem: got %h expected %h", {o_addr_log, o_read_log}, {15'h0123, 1'b1}); end
    tick(); tick();
    n_chk++; if (o_gpi !== 32'h0000_1234) begin n_fail++; $display("FAIL addr_mem_gpi: got %h expected 00001234", o_gpi); end
    tick(); tick();
  endtask

  task automatic test_back_to_back();
    i_log_data = 16'h0;
    pulse(8'd5, 23'h0011); tick();
    pulse(8'd5, 23'h0022); tick();
    pulse(8'd2, 23'd0);    tick();
    pulse(8'd1, 23'd1);
    repeat (6) tick();
    n_chk++; if (o_addr_log !== 15'h0022) begin n_fail++; $display("FAIL ovf_second_ran: got %h expected 0022", o_addr_log); end
    n_chk++; if ({o_enb_rx, o_enb_tx, o_busy} !== 3'b000) begin
      n_fail++; $display("FAIL ovf_rx_tx: got %b expected 000", {o_enb_rx, o_enb_tx, o_busy}); end
    pulse(8'd13, 23'd0); tick();
    n_chk++; if (o_gpi !== 32'h28) begin n_fail++; $display("FAIL ovf_status: got %h expected 00000028", o_gpi); end
    tick();
  endtask

  task automatic test_unknown();
    pulse(8'h55, 23'd0); tick();
    n_chk++; if (o_gpi !== 32'h0) begin n_fail++; $display("FAIL unk_gpi: got %h expected 0", o_gpi); end
    tick();
    pulse(8'd13, 23'd0); tick();
    n_chk++; if (o_gpi !== 32'h88) begin n_fail++; $display("FAIL unk_status1: got %h expected 00000088", o_gpi); end
    tick();
    pulse(8'd13, 23'd0); tick();
    n_chk++; if (o_gpi !== 32'h08) begin n_fail++; $display("FAIL unk_status2: got %h expected 00000008", o_gpi); end
    tick();
  endtask

  task automatic test_reset_mid();
    pulse(8'd5, 23'h0333); tick(); tick();
    n_chk++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b expected 1", o_busy); end
    i_gpo = {8'd1, 1'b1, 23'd1};
    i_resetn = 1'b0;
    #1;
    n_chk++; if ({o_rst, o_read_log, o_busy} !== 3'b100) begin
      n_fail++; $display("FAIL mid_rst_ctrl: got %b expected 100", {o_rst, o_read_log, o_busy}); end
    n_chk++; if ({o_addr_log, o_gpi} !== 47'h0) begin
      n_fail++; $display("FAIL mid_rst_data: got %h expected 0", {o_addr_log, o_gpi}); end
    tick(); tick();
    i_resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++; if ({o_enb_tx, o_busy, o_rst} !== 3'b001) begin
        n_fail++; $display("FAIL held_en_ignored: got %b expected 001", {o_enb_tx, o_busy, o_rst}); end
    end
    i_gpo = {8'd1, 1'b0, 23'd1};
    tick(); tick();
    pulse(8'd1, 23'd1); tick();
    n_chk++; if (o_enb_tx !== 1'b1) begin n_fail++; $display("FAIL rearmed_tx: got %b expected 1", o_enb_tx); end
    tick();
  endtask

  initial begin
    test_reset();
    test_ctrl();
    test_ber();
    test_read_mem();
    test_back_to_back();
    test_unknown();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/gpio_cmd_if.md
GPIO_CMD_IF -- requirements
Module: gpio_cmd_if

Interface
REQ-001 SHALL have parameter NB_GPIOS, default 32: width of the GPO/GPI words.
REQ-002 SHALL have parameter NB_CMD, default 8: command field width in i_gpo[NB_GPIOS-1 -: NB_CMD].
REQ-003 SHALL have parameter N_CH, default 2: number of BER channels.
REQ-004 SHALL have parameter NB_BER_CNT, default 64: width of each BER counter.
REQ-005 SHALL have parameter NB_PHASE, default 2: phase-select width.
REQ-006 SHALL have parameter BRAM_ADDR_WIDTH, default 15, and BRAM_DATA_WIDTH, default 16: log memory geometry.
REQ-007 SHALL have parameter MEM_LAT, default 2: log memory read latency in cycles.
REQ-008 clk100  in  1  sole clock; all logic on its rising edge.
REQ-009 i_resetn  in  1  asynchronous, active-low reset.
REQ-010 i_gpo  in  NB_GPIOS  {cmd, enable, data}; enable is bit NB_GPIOS-NB_CMD-1, and data is the bits below it (ND bits).
REQ-011 o_gpi  out  NB_GPIOS  readback word.
REQ-012 o_rst  out  1  system soft reset; o_enb_tx  out  1; o_enb_rx  out  1; o_phase_sel  out  NB_PHASE.
REQ-013 o_run_log  out  1  one-cycle start-logging pulse; o_read_log  out  1  memory read mode; o_addr_log  out  BRAM_ADDR_WIDTH.
REQ-014 i_log_data  in  BRAM_DATA_WIDTH; i_mem_full  in  1.
REQ-015 i_ber_samples, i_ber_errors  in  N_CH*NB_BER_CNT each  live counters, with channel c at slice [c*NB_BER_CNT +: NB_BER_CNT].
REQ-016 o_busy  out  1  high while FSM not IDLE.

Function
REQ-017 SHALL register i_gpo once per cycle; a command is accepted when the registered enable is 1 and its previous sample is 0. Cmd and data SHALL be captured from that same sample.
REQ-018 FSM states SHALL be IDLE, EXEC, MEM_WAIT. Transitions: IDLE->EXEC on accepted edge or pending flag; EXEC->MEM_WAIT for READ_MEM/ADDR_MEM; EXEC->IDLE otherwise; MEM_WAIT->IDLE after MEM_LAT cycles.
REQ-019 An edge arriving outside IDLE SHALL be stored in a one-deep pending slot. A further edge while pending is full SHALL be dropped and set sticky err_ovf.
REQ-020 Commands (data = d): 0 RESET o_rst<=d[0]; 1 EN_TX o_enb_tx<=d[0]; 2 EN_RX o_enb_rx<=d[0]; 3 PH_SEL o_phase_sel<=d[NB_PHASE-1:0].
REQ-021 Command 4 RUN_MEM SHALL pulse o_run_log high for exactly one cycle, in EXEC.
REQ-022 Command 5 READ_MEM SHALL set o_read_log<=1 and o_addr_log<=d[BRAM_ADDR_WIDTH-1:0].
REQ-023 Command 6 ADDR_MEM SHALL update o_addr_log only.
REQ-024 For commands 5 and 6, o_gpi SHALL equal zero-extended i_log_data sampled on the last MEM_WAIT cycle.
REQ-025 Command 7 BER_SNAP SHALL copy all 2*N_CH live counters into snapshot registers in the same cycle. Later reads SHALL return only snapshot values.
REQ-026 Command 8 BER_RD: d[7:0]=channel, d[8]=0 samples/1 errors, d[11:9]=word index w. o_gpi SHALL be snapshot bits [w*NB_GPIOS +: NB_GPIOS], zero-padded above NB_BER_CNT.
REQ-027 For BER_RD, channel >= N_CH or w >= ceil(NB_BER_CNT/NB_GPIOS) SHALL give o_gpi=0 and set sticky err_range.
REQ-028 Command 12 IS_MEM_FULL SHALL give o_gpi={0, i_mem_full}.
REQ-029 Command 13 STATUS SHALL give o_gpi={0, err_unknown, err_range, err_ovf, i_mem_full, o_read_log, o_enb_rx, o_enb_tx, o_rst} (LSB last) and clear all three sticky errors in the same cycle.
REQ-030 Any other command SHALL leave outputs unchanged except o_gpi=0, and SHALL set sticky err_unknown.
REQ-031 Commands 0-4 SHALL leave o_gpi unchanged.
REQ-032 Latency: for a command accepted at cycle k, control outputs and o_gpi SHALL update at k+1, except READ_MEM/ADDR_MEM o_gpi at k+1+MEM_LAT.
REQ-033 If an error set and a STATUS clear coincide, the set SHALL win.

Reset
REQ-034 Asserting i_resetn low SHALL immediately force o_rst=1, and all other outputs, snapshots, pending slot, sticky errors and FSM (IDLE) to 0. This holds mid-command, with any in-flight command discarded.
REQ-035 After reset release, an enable already held high SHALL NOT be accepted until it has been sampled low.

Verification
REQ-036 RESET, d=0, then EN_TX, d=1 -> o_rst 1->0 and o_enb_tx=1, each one cycle after its accepted edge.
REQ-037 Live samples ch1 = 0x0000_0001_8000_0000; BER_SNAP; then live counter changes; BER_RD ch1, samples, w=1 -> o_gpi=0x00000001; w=0 -> 0x80000000.
REQ-038 READ_MEM, addr 0x2A9C, with i_log_data=0xBEEF -> o_addr_log=0x2A9C and o_read_log=1 at k+1; o_gpi=0x0000BEEF at k+3; o_busy high k+1..k+3.
REQ-039 Three enable edges spaced 1 cycle apart during MEM_WAIT -> second executes after first, third dropped, and STATUS shows err_ovf=1.
REQ-040 Cmd 0x55, then STATUS, then STATUS -> first STATUS has err_unknown bit=1; second has it 0.
REQ-041 i_resetn low during MEM_WAIT -> outputs reset immediately; enable held high after release -> no command executes.
